// File: rtl/buzzer_pattern_driver.sv
// Two-channel buzzer pattern driver: per-channel on/off envelopes from obstacle levels, gated by a shared tone.
// Optional mute input when BUZZ_MUTE_EN is defined.
module buzzer_pattern_driver #(
  parameter int unsigned TONE_DIV = 12500,
  parameter int unsigned BEAT_DIV = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] left_buzz,
  input  logic [1:0] right_buzz,
`ifdef BUZZ_MUTE_EN
  input  logic       mute,
`endif
  output logic       left_tone,
  output logic       right_tone,
  output logic       left_active,
  output logic       right_active
);

  localparam int TW = $clog2(TONE_DIV);
  localparam int BW = $clog2(BEAT_DIV);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

  logic [1:0]        rstSync_q;
  logic              run;
  logic              runEna;
  logic              muteEff;

  logic [BW-1:0]     beatCnt_q, beatCnt_d;
  logic [TW-1:0]     toneCnt_q, toneCnt_d;
  logic              toneSq_q, toneSq_d;
  logic              tick;

  logic [1:0]        buzzIn;
  logic [1:0][1:0]   buzzLvl;
  logic [1:0][1:0]   lvl_q, lvl_d;
  logic [1:0][2:0]   phase_q, phase_d;
  logic [1:0]        active_q, active_d;
  logic [1:0]        tone_q, tone_d;

  assign buzzIn  = 2'b00;
  assign buzzLvl = {right_buzz, left_buzz};

`ifdef BUZZ_MUTE_EN
  assign muteEff = mute;
`else
  assign muteEff = 1'b0;
`endif

  // Release of rst_n is retimed through two flops; logic runs once the second one is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign run    = rstSync_q[1];
  assign runEna = run & ena;

  always_comb begin
    beatCnt_d = '0;
    toneCnt_d = '0;
    toneSq_d  = 1'b0;
    tick      = 1'b0;
    if (runEna) begin
      tick      = (beatCnt_q == BEAT_LAST);
      beatCnt_d = tick ? '0 : beatCnt_q + BW'(1);
      if (toneCnt_q == TONE_LAST) begin
        toneCnt_d = '0;
        toneSq_d  = ~toneSq_q;
      end else begin
        toneCnt_d = toneCnt_q + TW'(1);
        toneSq_d  = toneSq_q;
      end
    end
  end

  function automatic logic envelope(input logic [1:0] lvl, input logic [2:0] ph);
    logic on;
    case (lvl)
      2'd0:    on = 1'b0;
      2'd1:    on = ~ph[2];
      2'd2:    on = ~ph[0];
      default: on = 1'b1;
    endcase
    return on;
  endfunction

  // A level change restarts the pattern and wins over a coincident tick.
  always_comb begin
    lvl_d   = lvl_q;
    phase_d = phase_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (run) begin
        if (buzzLvl[ch] != lvl_q[ch]) begin
          lvl_d[ch]   = buzzLvl[ch];
          phase_d[ch] = 3'd0;
        end else if (!ena) begin
          phase_d[ch] = 3'd0;
        end else if (tick) begin
          phase_d[ch] = phase_q[ch] + 3'd1;
        end
      end
    end
  end

  always_comb begin
    active_d = 2'b00;
    tone_d   = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      active_d[ch] = runEna & envelope(lvl_q[ch], phase_q[ch]);
      tone_d[ch]   = active_d[ch] & toneSq_q & ~muteEff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beatCnt_q <= '0;
      toneCnt_q <= '0;
      toneSq_q  <= 1'b0;
      lvl_q     <= '0;
      phase_q   <= '0;
      active_q  <= 2'b00;
      tone_q    <= 2'b00;
    end else begin
      beatCnt_q <= beatCnt_d;
      toneCnt_q <= toneCnt_d;
      toneSq_q  <= toneSq_d;
      lvl_q     <= lvl_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
      tone_q    <= tone_d | buzzIn;
    end
  end

  assign left_active  = active_q[0];
  assign right_active = active_q[1];
  assign left_tone    = tone_q[0];
  assign right_tone   = tone_q[1];

endmodule

// File: tb/tb_buzzer_pattern_driver.sv
// Scoreboard bench for buzzer_pattern_driver with TONE_DIV=2, BEAT_DIV=4.
// Expected outputs per sample come from hand-derived timing windows of the directed scenario.
module tb_buzzer_pattern_driver;

  localparam int LAST = 195;

  typedef struct {
    int         cyc;
    logic [4:0] exp;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] left_buzz;
  logic [1:0] right_buzz;
  logic       mute;
  logic       left_tone, right_tone, left_active, right_active;

  entry_t     sb[$];
  int         cyc;
  int         errors;
  int         checks;

  buzzer_pattern_driver #(.TONE_DIV(2), .BEAT_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .left_buzz    (left_buzz),
    .right_buzz   (right_buzz),
`ifdef BUZZ_MUTE_EN
    .mute         (mute),
`endif
    .left_tone    (left_tone),
    .right_tone   (right_tone),
    .left_active  (left_active),
    .right_active (right_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square wave started by an enable seen at edge e+1: high on samples where (k-e) mod 4 is 2 or 3.
  function automatic bit sq(input int k, input int e);
    return (k > e) && (((k - e) % 4) >= 2);
  endfunction

  // Level-1 pattern restarted at edge l: on for 16 samples, off for 16.
  function automatic bit lOn(input int k, input int l);
    return (k > l) && (((k - l - 1) % 32) < 16);
  endfunction

  // Bits: {tone_sq, left_tone, right_tone, left_active, right_active}
  function automatic logic [4:0] expAt(input int k);
    bit s, ps, la, ra, m, muteTest;
    int e;
`ifdef BUZZ_MUTE_EN
    muteTest = 1'b1;
`else
    muteTest = 1'b0;
`endif
    if (k <= 8 || (k >= 111 && k <= 120) || (k >= 140 && k <= 150)) return 5'b00000;
    e  = (k <= 110) ? 8 : (k <= 139) ? 120 : 150;
    s  = sq(k, e);
    ps = sq(k - 1, e);
    if (k <= 110) begin
      la = lOn(k, 48);
      if (k <= 64)      ra = 1'b0;
      else if (k <= 70) ra = (((k - 65) % 8) < 4);
      else              ra = 1'b1;
    end else begin
      la = lOn(k, e);
      ra = 1'b1;
    end
    m = muteTest && (k >= 171) && (k <= 180);
    return {s, la & ps & ~m, ra & ps & ~m, la, ra};
  endfunction

  task automatic applyStimulus(input int k);
    case (k)
      3:   rst_n = 1'b1;
      8:   ena = 1'b1;
      47:  left_buzz = 2'd1;
      63:  right_buzz = 2'd2;
      69:  right_buzz = 2'd3;
      110: ena = 1'b0;
      120: ena = 1'b1;
      140: begin rst_n = 1'b0; ena = 1'b0; end
      143: rst_n = 1'b1;
      150: ena = 1'b1;
      170: mute = 1'b1;
      180: mute = 1'b0;
      default: ;
    endcase
  endtask

  task automatic checkOutput(input entry_t ent);
    logic [4:0] got;
    got = {dut.toneSq_q, left_tone, right_tone, left_active, right_active};
    checks = checks + 1;
    if (ent.cyc != cyc) begin
      errors = errors + 1;
      $display("[TB] FAIL sample_missed: expected sample %0d, monitor at %0d", ent.cyc, cyc);
    end else if (got !== ent.exp) begin
      errors = errors + 1;
      $display("[TB] FAIL outputs@%0d {sq,lt,rt,la,ra}: got %b, expected %b", cyc, got, ent.exp);
    end
  endtask

  initial begin
    entry_t ent;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        ent = sb.pop_front();
        checkOutput(ent);
      end
    end
  end

  initial begin
    entry_t ent;
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    ena        = 1'b0;
    left_buzz  = 2'd0;
    right_buzz = 2'd0;
    mute       = 1'b0;
    for (int k = 1; k <= LAST; k++) begin
      ent.cyc = k;
      ent.exp = expAt(k);
      sb.push_back(ent);
      @(posedge clk);
      cyc = k;
      #1;
      applyStimulus(k);
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors = errors + sb.size();
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
